// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: takes the ALU result as a byte address, runs a
// single req/ack access to data memory and returns extended load data.
module lsu_mem_stage #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_store,
    input  logic [2:0]            in_funct3,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata_out,
    output logic                  err
);

    // Counter only has to reach TIMEOUT_CYCLES-1
    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned CNT_MAX = TIMEOUT_CYCLES - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    in_ready_q, in_ready_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]              mem_wstrb_q, mem_wstrb_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    is_store_q, is_store_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [1:0]              off_q, off_d;

    logic                    req_legal;
    logic                    req_aligned;
    logic [DATA_WIDTH-1:0]   st_wdata;
    logic [3:0]              st_wstrb;
    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;
    logic [DATA_WIDTH-1:0]   ld_ext;

    // Decode legality and alignment of the incoming request
    always_comb begin
        req_legal   = 1'b0;
        req_aligned = 1'b0;
        case (in_funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = ~in_is_store;
            default:                req_legal = 1'b0;
        endcase
        case (in_funct3[1:0])
            2'b00:   req_aligned = 1'b1;
            2'b01:   req_aligned = ~in_addr[0];
            2'b10:   req_aligned = (in_addr[1:0] == 2'b00);
            default: req_aligned = 1'b0;
        endcase
    end

    // Lane-replicate store data and build byte strobes
    always_comb begin
        st_wdata = in_wdata;
        st_wstrb = 4'b1111;
        case (in_funct3[1:0])
            2'b00: begin
                st_wdata = {4{in_wdata[7:0]}};
                st_wstrb = 4'b0001 << in_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{in_wdata[15:0]}};
                st_wstrb = 4'b0011 << in_addr[1:0];
            end
            default: begin
                st_wdata = in_wdata;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Select the addressed lane of the read word and extend it
    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (off_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        is_store_d  = is_store_q;
        funct3_d    = funct3_q;
        off_d       = off_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    is_store_d = in_is_store;
                    funct3_d   = in_funct3;
                    off_d      = in_addr[1:0];
                    in_ready_d = 1'b0;
                    if (req_legal && req_aligned) begin
                        state_d     = S_REQ;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = in_is_store;
                        mem_addr_d  = {in_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata_d = in_is_store ? st_wdata : '0;
                        mem_wstrb_d = in_is_store ? st_wstrb : 4'b0000;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    rdata_d   = is_store_q ? '0 : ld_ext;
                end else if (cnt_q == CNT_W'(CNT_MAX)) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    rdata_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                in_ready_d = 1'b1;
            end
            default: begin
                state_d    = S_IDLE;
                in_ready_d = 1'b1;
                mem_req_d  = 1'b0;
                mem_we_d   = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= 4'b0000;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            is_store_q  <= is_store_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata_out = rdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a transaction-level reference model.
module tb_lsu_mem_stage;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        done;
    logic [31:0] rdata_out;
    logic        err;

    lsu_mem_stage #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_is_store (in_is_store),
        .in_funct3   (in_funct3),
        .in_addr     (in_addr),
        .in_wdata    (in_wdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .done        (done),
        .rdata_out   (rdata_out),
        .err         (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Expected outputs for the current cycle
    bit          check_en = 1'b0;
    logic        exp_ready, exp_req, exp_we, exp_done, exp_err;
    logic [31:0] exp_addr, exp_wdata, exp_rout;
    logic [3:0]  exp_wstrb;

    // Observations used by the literal checks
    int          seen_req_cnt = 0;
    int          done_cyc     = 0;
    int          acc_cyc      = 0;
    logic [31:0] seen_addr    = '0;
    logic [31:0] seen_wdata   = '0;
    logic [3:0]  seen_wstrb   = '0;
    logic        seen_we      = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    // Reference model: what one request must produce, from the ISA rules
    task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         output bit e, output logic [31:0] maddr, output logic [31:0] mwdata,
                         output logic [3:0] mwstrb, output logic [31:0] lres);
        int          size;
        int          off;
        bit          legal;
        bit          sgn;
        logic [31:0] mask;
        logic [31:0] v;
        size  = 0;
        sgn   = 1'b0;
        legal = 1'b1;
        case (f3)
            3'd0:    begin size = 1; sgn = 1'b1; end
            3'd1:    begin size = 2; sgn = 1'b1; end
            3'd2:    size = 4;
            3'd4:    begin size = 1; legal = !st; end
            3'd5:    begin size = 2; legal = !st; end
            default: legal = 1'b0;
        endcase
        off   = int'(addr % 32'd4);
        e     = !legal || (size == 0) || ((off % size) != 0);
        maddr = addr - 32'(off);
        mask  = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        if (st) begin
            if (size == 1)      mwdata = (wdata & 32'hFF) * 32'h0101_0101;
            else if (size == 2) mwdata = (wdata & 32'hFFFF) * 32'h0001_0001;
            else                mwdata = wdata;
            mwstrb = 4'(((1 << size) - 1) << off);
            lres   = '0;
        end else begin
            mwdata = '0;
            mwstrb = 4'b0000;
            v = (rdata >> (8 * off)) & mask;
            if (sgn && size < 4 && size > 0 && v[8 * size - 1]) v = v | ~mask;
            lres = v;
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model expectations
    always @(negedge clk) begin
        cyc++;
        if (check_en) begin
            chk("in_ready", 32'(in_ready), 32'(exp_ready));
            chk("mem_req", 32'(mem_req), 32'(exp_req));
            chk("done", 32'(done), 32'(exp_done));
            chk("rdata_out", rdata_out, exp_rout);
            if (exp_done) chk("err", 32'(err), 32'(exp_err));
            if (exp_req) begin
                chk("mem_we", 32'(mem_we), 32'(exp_we));
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_wdata", mem_wdata, exp_wdata);
                chk("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
            end
            if (mem_req) begin
                seen_req_cnt++;
                seen_addr  = mem_addr;
                seen_wdata = mem_wdata;
                seen_wstrb = mem_wstrb;
                seen_we    = mem_we;
            end
            if (done) done_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        exp_ready = 1'b1;
        exp_req   = 1'b0;
        exp_we    = 1'b0;
        exp_done  = 1'b0;
        exp_err   = 1'b0;
    endtask

    // One request; ack_at = REQ-cycle index of mem_ack, negative for none
    task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input int ack_at);
        bit          e;
        bit          acked;
        logic [31:0] ma, mw, lr;
        logic [3:0]  ws;
        model(st, f3, addr, wdata, rdata, e, ma, mw, ws, lr);
        acked = 1'b0;
        step();
        idle_exp();
        in_valid     = 1'b1;
        in_is_store  = st;
        in_funct3    = f3;
        in_addr      = addr;
        in_wdata     = wdata;
        mem_ack      = 1'b0;
        acc_cyc      = cyc + 1;
        seen_req_cnt = 0;
        step();
        // Busy: keep offering a different request, which must be ignored
        in_is_store = ~st;
        in_funct3   = ~f3;
        in_addr     = ~addr;
        in_wdata    = ~wdata;
        exp_ready   = 1'b0;
        if (!e) begin
            exp_req   = 1'b1;
            exp_we    = st;
            exp_addr  = ma;
            exp_wdata = mw;
            exp_wstrb = ws;
            for (int k = 0; k < int'(TO); k++) begin
                if (k > 0) step();
                mem_ack   = (k == ack_at);
                mem_rdata = (k == ack_at) ? rdata : ~rdata;
                if (k == ack_at) begin
                    acked = 1'b1;
                    break;
                end
            end
            step();
        end
        exp_req  = 1'b0;
        exp_we   = 1'b0;
        exp_done = 1'b1;
        exp_err  = e || !acked;
        exp_rout = (!st && !e && acked) ? lr : 32'd0;
        mem_ack  = 1'b1;
        step();
        in_valid = 1'b0;
        mem_ack  = 1'b0;
        idle_exp();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_is_store = 1'b0;
        in_funct3   = 3'b000;
        in_addr     = '0;
        in_wdata    = '0;
        mem_rdata   = '0;
        mem_ack     = 1'b0;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_rdata_out", rdata_out, 32'd0);
        reset = 1'b0;
        idle_exp();
        exp_rout = '0;
        check_en = 1'b1;

        // LW, ack two cycles after mem_req rises
        run_txn(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 2);
        chk("lw_rdata_lit", rdata_out, 32'hDEAD_BEEF);
        chk("lw_addr_lit", seen_addr, 32'h0000_0100);
        chk("lw_wstrb_lit", 32'(seen_wstrb), 32'd0);
        chk("lw_latency_lit", 32'(done_cyc - acc_cyc), 32'd4);

        // LB / LBU on the top lane, zero-wait memory
        run_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0);
        chk("lb_rdata_lit", rdata_out, 32'hFFFF_FF80);
        run_txn(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0);
        chk("lbu_rdata_lit", rdata_out, 32'h0000_0080);
        chk("lbu_latency_lit", 32'(done_cyc - acc_cyc), 32'd2);

        // SH to the upper half
        run_txn(1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 1);
        chk("sh_addr_lit", seen_addr, 32'h0000_0200);
        chk("sh_wdata_lit", seen_wdata, 32'hABCD_ABCD);
        chk("sh_wstrb_lit", 32'(seen_wstrb), 32'b1100);
        chk("sh_we_lit", 32'(seen_we), 32'd1);
        chk("sh_rdata_lit", rdata_out, 32'd0);

        // Other widths and lanes
        run_txn(1'b1, 3'b000, 32'h0000_0011, 32'h1234_56AB, 32'h0, 0);
        run_txn(1'b0, 3'b001, 32'h0000_0022, 32'h0, 32'h8001_7FFF, 1);
        chk("lh_rdata_lit", rdata_out, 32'hFFFF_8001);
        run_txn(1'b0, 3'b101, 32'h0000_0022, 32'h0, 32'h8001_7FFF, 0);
        run_txn(1'b0, 3'b000, 32'h0000_0040, 32'h0, 32'h0000_007F, 0);

        // Misaligned and illegal: done at N+1, no memory access, rdata cleared
        run_txn(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 0);
        chk("misal_latency_lit", 32'(done_cyc - acc_cyc), 32'd1);
        chk("misal_noreq_lit", 32'(seen_req_cnt), 32'd0);
        chk("misal_rdata_lit", rdata_out, 32'd0);
        run_txn(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 0);
        chk("illegal_noreq_lit", 32'(seen_req_cnt), 32'd0);
        run_txn(1'b0, 3'b001, 32'h0000_0103, 32'h0, 32'h0, 0);
        run_txn(1'b1, 3'b100, 32'h0000_0000, 32'h5555_5555, 32'h0, 0);
        run_txn(1'b1, 3'b001, 32'h0000_0001, 32'h5555_5555, 32'h0, 0);

        // Timeout with no ack, then ack in the last allowed cycle
        run_txn(1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'h0, -1);
        chk("to_req_cycles_lit", 32'(seen_req_cnt), 32'd4);
        run_txn(1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'h0, 3);
        chk("to_edge_latency_lit", 32'(done_cyc - acc_cyc), 32'd5);
        run_txn(1'b0, 3'b010, 32'h0000_0304, 32'h0, 32'h0BAD_F00D, 3);

        // Reset in the middle of REQ
        step();
        idle_exp();
        in_valid    = 1'b1;
        in_is_store = 1'b0;
        in_funct3   = 3'b010;
        in_addr     = 32'h0000_0400;
        step();
        in_valid = 1'b0;
        exp_ready = 1'b0;
        exp_req   = 1'b1;
        exp_we    = 1'b0;
        exp_addr  = 32'h0000_0400;
        exp_wdata = 32'd0;
        exp_wstrb = 4'b0000;
        @(negedge clk);
        #1;
        check_en = 1'b0;
        reset    = 1'b1;
        #1;
        chk("rst_req_drop", 32'(mem_req), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_nodone", 32'(done), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_1111;
        step();
        step();
        chk("rst_nodone_hold", 32'(done), 32'd0);
        mem_ack = 1'b0;
        reset   = 1'b0;
        idle_exp();
        exp_rout = '0;
        check_en = 1'b1;
        run_txn(1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h1357_9BDF, 1);
        chk("post_rst_lw_lit", rdata_out, 32'h1357_9BDF);

        step();
        step();
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
